// File: rtl/johnson_seq_pkg.sv
// Shared types and defaults for the Johnson-ring step sequencer.
// Optional build macro JSEQ_IDLE_DEENERGIZE_EN is consumed by the top level only.
package johnson_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   localparam int PHASES_DEF = 4;
   localparam int CNT_W_DEF  = 16;
   localparam int DIV_W_DEF  = 16;

endpackage

// File: rtl/johnson_ring.sv
// Bidirectional Johnson-code ring register; steps once per cycle when step_en is high.
// Pure datapath with asynchronous active-low clear, no sequencing logic.
module johnson_ring
   import johnson_seq_pkg::*;
#(
   parameter int PHASES = PHASES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step_en,
   input  logic              dir,
   output logic [PHASES-1:0] phase
);

   logic [PHASES-1:0] ring_reg;
   logic [PHASES-1:0] ring_next;
   logic [PHASES-1:0] fwd_next;
   logic [PHASES-1:0] rev_next;

   // Forward shifts toward the MSB feeding ~MSB into bit 0; reverse mirrors it.
   generate
      for (genvar gi = 0; gi < PHASES; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign fwd_next[gi] = ~ring_reg[PHASES-1];
         end else begin : g_fwd
            assign fwd_next[gi] = ring_reg[gi-1];
         end
         if (gi == PHASES-1) begin : g_msb
            assign rev_next[gi] = ~ring_reg[0];
         end else begin : g_rev
            assign rev_next[gi] = ring_reg[gi+1];
         end
      end
   endgenerate

   always_comb begin
      ring_next = ring_reg;
      if (step_en) begin
         ring_next = (dir == DIR_FWD) ? fwd_next : rev_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ring_reg <= '0;
      end else begin
         ring_reg <= ring_next;
      end
   end

   assign phase = ring_reg;

endmodule

// File: rtl/johnson_step_sequencer.sv
// Command-driven move controller: FSM, step-period divider and step counter around johnson_ring.
// Define JSEQ_IDLE_DEENERGIZE_EN to blank phase_out outside RUN while the ring keeps its position.
module johnson_step_sequencer
   import johnson_seq_pkg::*;
#(
   parameter int PHASES = PHASES_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CNT_W-1:0]  cmd_steps,
   input  logic              cmd_dir,
   input  logic [DIV_W-1:0]  cmd_period,
   input  logic              abort,
   output logic [PHASES-1:0] phase_out,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [CNT_W-1:0]  steps_left
);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   steps_left_reg, steps_left_next;
   logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
   logic [DIV_W-1:0]   period_reg, period_next;
   logic               dir_reg, dir_next;
   logic               aborted_reg, aborted_next;
   logic               step_en;
   logic [PHASES-1:0]  ring_phase;

   always_comb begin
      state_next      = state_reg;
      steps_left_next = steps_left_reg;
      div_cnt_next    = div_cnt_reg;
      period_next     = period_reg;
      dir_next        = dir_reg;
      aborted_next    = aborted_reg;
      step_en         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // abort has no meaning here; a valid command is always taken
            if (cmd_valid) begin
               dir_next        = cmd_dir;
               period_next     = cmd_period;
               steps_left_next = cmd_steps;
               div_cnt_next    = cmd_period;
               aborted_next    = 1'b0;
               state_next      = (cmd_steps == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               aborted_next = 1'b1;
               state_next   = ST_DONE;
            end else if (div_cnt_reg == '0) begin
               step_en         = 1'b1;
               steps_left_next = steps_left_reg - CNT_W'(1);
               div_cnt_next    = period_reg;
               if (steps_left_reg == CNT_W'(1)) begin
                  state_next = ST_DONE;
               end
            end else begin
               div_cnt_next = div_cnt_reg - DIV_W'(1);
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         steps_left_reg <= '0;
         div_cnt_reg    <= '0;
         period_reg     <= '0;
         dir_reg        <= DIR_REV;
         aborted_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         steps_left_reg <= steps_left_next;
         div_cnt_reg    <= div_cnt_next;
         period_reg     <= period_next;
         dir_reg        <= dir_next;
         aborted_reg    <= aborted_next;
      end
   end

   johnson_ring #(
      .PHASES (PHASES)
   ) u_ring (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_en (step_en),
      .dir     (dir_reg),
      .phase   (ring_phase)
   );

   assign cmd_ready  = (state_reg == ST_IDLE);
   assign busy       = (state_reg == ST_RUN);
   assign done       = (state_reg == ST_DONE);
   assign aborted    = aborted_reg;
   assign steps_left = steps_left_reg;

`ifdef JSEQ_IDLE_DEENERGIZE_EN
   assign phase_out = (state_reg == ST_RUN) ? ring_phase : '0;
`else
   assign phase_out = ring_phase;
`endif

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Self-checking bench: directed moves with literal expectations plus a per-cycle
// comparison against an elapsed-time model of the sequencer.
module tb_johnson_step_sequencer;

   localparam int PH    = 4;
   localparam int CNT_W = 16;
   localparam int DIV_W = 16;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_steps = '0;
   logic             cmd_dir = 1'b0;
   logic [DIV_W-1:0] cmd_period = '0;
   logic             abort = 1'b0;
   logic [PH-1:0]    phase_out;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] steps_left;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;
   int move_id  = 0;

   johnson_step_sequencer #(
      .PHASES (PH),
      .CNT_W  (CNT_W),
      .DIV_W  (DIV_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_steps  (cmd_steps),
      .cmd_dir    (cmd_dir),
      .cmd_period (cmd_period),
      .abort      (abort),
      .phase_out  (phase_out),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .steps_left (steps_left)
   );

   always #5 clk = ~clk;

   // ---------------- model: ring position as an index 0..2*PH-1 ----------------
   int m_mode = M_IDLE;
   int m_pos  = 0;
   int m_left = 0;
   int m_p    = 0;
   int m_t    = 0;
   bit m_dir  = 1'b0;
   bit m_abt  = 1'b0;

   // Johnson code at index i: i ones filling from bit 0, then zeros filling from bit 0.
   function automatic logic [PH-1:0] jcode(int i);
      int ones;
      if (i <= PH) begin
         ones = (1 << i) - 1;
      end else begin
         ones = ((1 << PH) - 1) & ~((1 << (i - PH)) - 1);
      end
      return PH'(ones);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= M_IDLE;
         m_pos  <= 0;
         m_left <= 0;
         m_p    <= 0;
         m_t    <= 0;
         m_dir  <= 1'b0;
         m_abt  <= 1'b0;
      end else begin
         case (m_mode)
            M_IDLE: if (cmd_valid) begin
               m_left <= int'(cmd_steps);
               m_p    <= int'(cmd_period);
               m_dir  <= cmd_dir;
               m_t    <= 0;
               m_abt  <= 1'b0;
               m_mode <= (cmd_steps == 0) ? M_DONE : M_RUN;
            end
            M_RUN: if (abort) begin
               m_abt  <= 1'b1;
               m_mode <= M_DONE;
            end else begin
               m_t <= m_t + 1;
               if ((m_t + 1) % (m_p + 1) == 0) begin
                  m_left <= m_left - 1;
                  m_pos  <= m_dir ? (m_pos + 1) % (2*PH) : (m_pos + 2*PH - 1) % (2*PH);
                  if (m_left == 1) m_mode <= M_DONE;
               end
            end
            default: m_mode <= M_IDLE;
         endcase
      end
   end

   function automatic logic [PH-1:0] model_phase();
      logic [PH-1:0] e;
      e = jcode(m_pos);
`ifdef JSEQ_IDLE_DEENERGIZE_EN
      if (m_mode != M_RUN) e = '0;
`endif
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_phase",      32'(phase_out),  32'(model_phase()));
         check("cmp_cmd_ready",  32'(cmd_ready),  32'(m_mode == M_IDLE));
         check("cmp_busy",       32'(busy),       32'(m_mode == M_RUN));
         check("cmp_done",       32'(done),       32'(m_mode == M_DONE));
         check("cmp_aborted",    32'(aborted),    32'(m_abt));
         check("cmp_steps_left", 32'(steps_left), 32'(m_left));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ph(string name, logic [PH-1:0] code, bit in_run);
      logic [PH-1:0] e;
      e = code;
`ifdef JSEQ_IDLE_DEENERGIZE_EN
      if (!in_run) e = '0;
`endif
      check(name, 32'(phase_out), 32'(e));
   endtask

   // Waits (bounded) for IDLE, presents one command for exactly one accept edge.
   task automatic start_move(int steps, bit dir, int period);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      check("idle_before_accept", 32'(cmd_ready), 32'd1);
      move_id++;
      $display("move %0d: steps=%0d dir=%0d period=%0d", move_id, steps, dir, period);
      cmd_valid  = 1'b1;
      cmd_steps  = CNT_W'(steps);
      cmd_dir    = dir;
      cmd_period = DIV_W'(period);
      tick();
      cmd_valid  = 1'b0;
   endtask

   logic [PH-1:0] rev_exp [9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rev_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                  4'b0011, 4'b0001, 4'b0000, 4'b1000};

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_phase",     32'(phase_out), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_steps",     32'(steps_left),32'd0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      tick();

      // Forward 3, period 1: steps at edges 2, 4, 6
      start_move(3, 1'b1, 1);
      tick();
      tick();
      check_ph("fwd3_step1", 4'b0001, 1'b1);
      tick();
      tick();
      check_ph("fwd3_step2", 4'b0011, 1'b1);
      tick();
      tick();
      check_ph("fwd3_step3", 4'b0111, 1'b0);
      check("fwd3_done",    32'(done),       32'd1);
      check("fwd3_left",    32'(steps_left), 32'd0);
      check("fwd3_aborted", 32'(aborted),    32'd0);
      tick();
      check("fwd3_done_low", 32'(done), 32'd0);

      // Re-zero the ring for the reverse wrap test
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // Reverse 9, period 0 from 0000
      start_move(9, 1'b0, 0);
      for (int k = 0; k < 9; k++) begin
         tick();
         check_ph("rev9_step", rev_exp[k], k < 8);
      end
      check("rev9_done", 32'(done), 32'd1);
      tick();

      // Zero-step move: no busy, done right after accept, ring unchanged
      start_move(0, 1'b1, 5);
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check_ph("zero_phase", 4'b1000, 1'b0);
      tick();
      check("zero_idle", 32'(cmd_ready), 32'd1);

      // Forward 10, period 3, abort sampled at edge 10: steps at 4 and 8 only
      start_move(10, 1'b1, 3);
      repeat (9) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_done",    32'(done),       32'd1);
      check("abort_flag",    32'(aborted),    32'd1);
      check("abort_left",    32'(steps_left), 32'd8);
      check_ph("abort_phase", 4'b0001, 1'b0);
      tick();

      // Back-to-back with cmd_valid held: cmd changes while busy are ignored,
      // abort in IDLE is ignored, and the second accept lands 2 edges after done.
      move_id++;
      $display("move %0d: steps=2 dir=1 period=1 (valid held)", move_id);
      cmd_valid  = 1'b1;
      cmd_steps  = 16'd2;
      cmd_dir    = 1'b1;
      cmd_period = 16'd1;
      tick();
      cmd_steps  = 16'd5;
      cmd_dir    = 1'b0;
      cmd_period = 16'd0;
      repeat (4) tick();
      check("b2b_done1", 32'(done), 32'd1);
      check_ph("b2b_phase1", 4'b0111, 1'b0);
      tick();
      move_id++;
      $display("move %0d: steps=5 dir=0 period=0 (abort held at accept)", move_id);
      abort = 1'b1;
      tick();
      abort     = 1'b0;
      cmd_valid = 1'b0;
      check("b2b_busy2",    32'(busy),       32'd1);
      check("b2b_aborted2", 32'(aborted),    32'd0);
      check("b2b_left2",    32'(steps_left), 32'd5);
      repeat (5) tick();
      check("b2b_done2", 32'(done), 32'd1);
      check_ph("b2b_phase2", 4'b1100, 1'b0);
      tick();

      // Asynchronous reset in the middle of a move
      start_move(10, 1'b1, 1);
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_phase",   32'(phase_out),  32'd0);
      check("mid_rst_left",    32'(steps_left), 32'd0);
      check("mid_rst_busy",    32'(busy),       32'd0);
      check("mid_rst_done",    32'(done),       32'd0);
      check("mid_rst_ready",   32'(cmd_ready),  32'd1);
      check("mid_rst_aborted", 32'(aborted),    32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Position held across IDLE (blanked when de-energize is built in), then resumed
      start_move(3, 1'b1, 0);
      repeat (3) tick();
      tick();
      check_ph("idle_hold_phase", 4'b0111, 1'b0);
      start_move(2, 1'b1, 0);
      check_ph("resume_pre_step", 4'b0111, 1'b1);
      tick();
      check_ph("resume_step1", 4'b1111, 1'b1);
      tick();
      check_ph("resume_step2", 4'b1110, 1'b0);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
